pipeline_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline. It combines the load-use hazard request, EX-stage redirects (taken branch/jump, trap), and instruction/data memory wait states into per-stage register enables, per-stage flushes and the PC source select. A state machine covers multi-cycle data-memory waits with a timeout that raises a bus-error trap, and covers the one-cycle refill bubble after a redirect.

---
 rtl/pipeline_controller.sv | 177 +++++++++++++++++
 tb/tb_pipeline_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_controller #(
  parameter int unsigned DMEM_TIMEOUT  = 255,
  parameter int unsigned REFILL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_hazard,
  input  logic        ex_branch_taken,
  input  logic        ex_trap,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [1:0]  pc_sel,
  output logic        bus_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    REFILL    = 2'd2
  } state_e;

  localparam logic [7:0] TMO     = 8'(DMEM_TIMEOUT);
  localparam logic [1:0] RC_LAST = 2'(REFILL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic [1:0] ref_q, ref_d;
  logic [4:0] en;
  logic [2:0] fl;
  logic       redirect;
  logic       rules;
  logic       rule1_ok;
  logic       dstall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tmo_q   <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      ref_q   <= ref_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    ref_d    = ref_q;
    en       = '0;
    fl       = '0;
    pc_sel   = 2'b00;
    bus_err  = 1'b0;
    redirect = 1'b0;
    rules    = 1'b0;
    rule1_ok = 1'b0;
    dstall   = dmem_req & ~dmem_ready;

    case (state_q)
      RUN: begin
        rules    = 1'b1;
        rule1_ok = 1'b1;
      end
      DMEM_WAIT: begin
        if (dmem_ready) begin
          rules   = 1'b1;
          state_d = RUN;
        end else if (tmo_q == TMO) begin
          bus_err  = 1'b1;
          pc_sel   = 2'b10;
          fl       = 3'b111;
          en       = '1;
          redirect = 1'b1;
          state_d  = REFILL;
          ref_d    = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      REFILL: begin
        rules    = 1'b1;
        rule1_ok = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (rules) begin
      if (rule1_ok && dstall) begin
        state_d = DMEM_WAIT;
        tmo_d   = 8'd1;
      end else if (ex_trap) begin
        pc_sel   = 2'b10;
        fl       = 3'b111;
        en       = '1;
        redirect = 1'b1;
        state_d  = REFILL;
        ref_d    = '0;
      end else if (ex_branch_taken) begin
        pc_sel   = 2'b01;
        fl       = 3'b110;
        en       = '1;
        redirect = 1'b1;
        state_d  = REFILL;
        ref_d    = '0;
      end else if (state_q == REFILL) begin
        // ID keeps a bubble until enough real fetches arrive
        fl = 3'b100;
        en = {imem_ready, 4'b1111};
        if (imem_ready) begin
          if (ref_q == RC_LAST) state_d = RUN;
          else ref_d = ref_q + 2'd1;
        end
      end else if (load_use_hazard) begin
        en = 5'b00111;
        fl = 3'b001;
      end else if (!imem_ready) begin
        en = 5'b01111;
        fl = 3'b100;
      end else begin
        en = '1;
      end
    end

    if (rst) begin
      en       = '0;
      fl       = 3'b111;
      pc_sel   = 2'b00;
      bus_err  = 1'b0;
      redirect = 1'b0;
    end
  end

  assign {if_en, id_en, ex_en, mem_en, wb_en} = en;
  assign {flush_if, flush_id, flush_ex}       = fl;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + {31'd0, ~if_en};
      flush_q <= flush_q + {31'd0, redirect};
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

  // a flushed register's loader must be advancing
  a_flush_hold: assert property (@(posedge clk) disable iff (rst)
    (!flush_if || id_en) && (!flush_id || ex_en) && (!flush_ex || mem_en));
  a_pc_sel: assert property (@(posedge clk) pc_sel != 2'b11);
  a_redirect: assert property (@(posedge clk) disable iff (rst)
    redirect |-> (pc_sel != 2'b00));

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: fixed vectors, corner sequences and a
// randomized run compared with a cycle-level reference model.
module tb_pipeline_controller;

  localparam int TMO0 = 8;
  localparam int RC0  = 1;
  localparam int TMO1 = 3;
  localparam int RC1  = 3;

  logic clk;
  logic rst, lu, br, tr, im, dq, dr;

  logic [1:0]  ifen_w, iden_w, exen_w, memen_w, wben_w;
  logic [1:0]  fif_w, fid_w, fex_w, be_w;
  logic [1:0]  pc_w [2];
  logic [31:0] sc_w [2];
  logic [31:0] fe_w [2];

  int nvec = 0;
  int nmis = 0;

  int          wait_n  [2] = '{0, 0};
  int          refill_n[2] = '{0, 0};
  logic [31:0] m_stall [2] = '{32'd0, 32'd0};
  logic [31:0] m_flush [2] = '{32'd0, 32'd0};

  pipeline_controller #(.DMEM_TIMEOUT(TMO0), .REFILL_CYCLES(RC0)) u_dut0 (
    .clk(clk), .rst(rst), .load_use_hazard(lu), .ex_branch_taken(br),
    .ex_trap(tr), .imem_ready(im), .dmem_req(dq), .dmem_ready(dr),
    .if_en(ifen_w[0]), .id_en(iden_w[0]), .ex_en(exen_w[0]),
    .mem_en(memen_w[0]), .wb_en(wben_w[0]),
    .flush_if(fif_w[0]), .flush_id(fid_w[0]), .flush_ex(fex_w[0]),
    .pc_sel(pc_w[0]), .bus_err(be_w[0]),
    .stall_cycles(sc_w[0]), .flush_events(fe_w[0])
  );

  pipeline_controller #(.DMEM_TIMEOUT(TMO1), .REFILL_CYCLES(RC1)) u_dut1 (
    .clk(clk), .rst(rst), .load_use_hazard(lu), .ex_branch_taken(br),
    .ex_trap(tr), .imem_ready(im), .dmem_req(dq), .dmem_ready(dr),
    .if_en(ifen_w[1]), .id_en(iden_w[1]), .ex_en(exen_w[1]),
    .mem_en(memen_w[1]), .wb_en(wben_w[1]),
    .flush_if(fif_w[1]), .flush_id(fid_w[1]), .flush_ex(fex_w[1]),
    .pc_sel(pc_w[1]), .bus_err(be_w[1]),
    .stall_cycles(sc_w[1]), .flush_events(fe_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected {en[if,id,ex,mem,wb], flush[if,id,ex], pc_sel, bus_err}
  function automatic logic [10:0] model(input int k);
    logic [4:0] e;
    logic [2:0] f;
    logic [1:0] p;
    logic       b;
    bit         redir, ws, rf;
    int         tmo, rc;
    tmo = (k == 0) ? TMO0 : TMO1;
    rc  = (k == 0) ? RC0 : RC1;
    e = '0; f = '0; p = '0; b = 1'b0; redir = 0;
    ws = wait_n[k] > 0;
    rf = refill_n[k] > 0;
    if (rst) begin
      wait_n[k] = 0; refill_n[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0;
      return {5'b00000, 3'b111, 2'b00, 1'b0};
    end
    if (ws && !dr) begin
      if (wait_n[k] == tmo) begin
        e = '1; f = '1; p = 2'b10; b = 1'b1; redir = 1;
        wait_n[k] = 0; refill_n[k] = rc;
      end else begin
        wait_n[k]++;
      end
    end else if (!ws && dq && !dr) begin
      wait_n[k] = 1; refill_n[k] = 0;
    end else begin
      wait_n[k] = 0;
      if (tr) begin
        e = '1; f = 3'b111; p = 2'b10; redir = 1; refill_n[k] = rc;
      end else if (br) begin
        e = '1; f = 3'b110; p = 2'b01; redir = 1; refill_n[k] = rc;
      end else if (rf) begin
        e = {im, 4'hf}; f = 3'b100;
        if (im) refill_n[k]--;
      end else if (lu) begin
        e = 5'b00111; f = 3'b001;
      end else if (!im) begin
        e = 5'b01111; f = 3'b100;
      end else begin
        e = '1;
      end
    end
    if (!e[4]) m_stall[k]++;
    if (redir) m_flush[k]++;
    return {e, f, p, b};
  endfunction

  task automatic step(input logic [6:0] in, input bit use_tbl,
                      input logic [10:0] tbl_exp, input string nm);
    logic [10:0] exp, act;
    {rst, lu, br, tr, im, dq, dr} = in;
    #2;
    for (int k = 0; k < 2; k++) begin
`ifdef PIPE_PERF_CNT_EN
      chk($sformatf("%s/d%0d stall_cycles", nm, k), sc_w[k], m_stall[k]);
      chk($sformatf("%s/d%0d flush_events", nm, k), fe_w[k], m_flush[k]);
`else
      chk($sformatf("%s/d%0d stall_cycles", nm, k), sc_w[k], 32'd0);
      chk($sformatf("%s/d%0d flush_events", nm, k), fe_w[k], 32'd0);
`endif
      exp = model(k);
      if (k == 0 && use_tbl) exp = tbl_exp;
      act = {ifen_w[k], iden_w[k], exen_w[k], memen_w[k], wben_w[k],
             fif_w[k], fid_w[k], fex_w[k], pc_w[k], be_w[k]};
      chk($sformatf("%s/d%0d outs", nm, k), 32'(act), 32'(exp));
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [6:0]  in;
    logic [10:0] ex;
  } vec_t;

  vec_t tbl[24];

  initial begin
    // inputs {rst,lu,br,trap,imem_rdy,dmem_req,dmem_rdy}
    tbl[0]  = '{7'b1000100, 11'b00000_111_00_0};
    tbl[1]  = '{7'b1000100, 11'b00000_111_00_0};
    tbl[2]  = '{7'b1000100, 11'b00000_111_00_0};
    tbl[3]  = '{7'b0000100, 11'b11111_000_00_0};
    tbl[4]  = '{7'b0100100, 11'b00111_001_00_0};
    tbl[5]  = '{7'b0000100, 11'b11111_000_00_0};
    tbl[6]  = '{7'b0000000, 11'b01111_100_00_0};
    tbl[7]  = '{7'b0000110, 11'b00000_000_00_0};
    tbl[8]  = '{7'b0000110, 11'b00000_000_00_0};
    tbl[9]  = '{7'b0000110, 11'b00000_000_00_0};
    tbl[10] = '{7'b0000110, 11'b00000_000_00_0};
    tbl[11] = '{7'b0000111, 11'b11111_000_00_0};
    tbl[12] = '{7'b0110100, 11'b11111_110_01_0};
    tbl[13] = '{7'b0000100, 11'b11111_100_00_0};
    tbl[14] = '{7'b0000100, 11'b11111_000_00_0};
    tbl[15] = '{7'b0011100, 11'b11111_111_10_0};
    tbl[16] = '{7'b0000000, 11'b01111_100_00_0};
    tbl[17] = '{7'b0000100, 11'b11111_100_00_0};
    tbl[18] = '{7'b0001100, 11'b11111_111_10_0};
    tbl[19] = '{7'b0000110, 11'b00000_000_00_0};
    tbl[20] = '{7'b0001111, 11'b11111_111_10_0};
    tbl[21] = '{7'b0000100, 11'b11111_100_00_0};
    tbl[22] = '{7'b0000100, 11'b11111_000_00_0};
    tbl[23] = '{7'b0000111, 11'b11111_000_00_0};

    {rst, lu, br, tr, im, dq, dr} = 7'b1000100;
    @(negedge clk);

    for (int i = 0; i < 24; i++)
      step(tbl[i].in, 1, tbl[i].ex, $sformatf("tbl%0d", i));

    // DMEM timeout: stall cycle in RUN plus 8 wait cycles, pulse on the last
    for (int i = 0; i < 9; i++)
      step(7'b0000110, 1,
           (i == 8) ? 11'b11111_111_10_1 : 11'b00000_000_00_0,
           $sformatf("tmo%0d", i));
    step(7'b0000100, 1, 11'b11111_100_00_0, "tmo_refill");
    step(7'b0000100, 1, 11'b11111_000_00_0, "tmo_run");

    // trap beats branch, then reset lands in REFILL
    step(7'b0011100, 1, 11'b11111_111_10_0, "trap_br");
    step(7'b1000100, 1, 11'b00000_111_00_0, "rst_refill");
    chk("flush_events_after_rst", fe_w[0], 32'd0);
    step(7'b0000100, 1, 11'b11111_000_00_0, "post_rst");

    for (int i = 0; i < 800; i++) begin
      bit slow;
      logic [6:0] v;
      slow = ((i / 60) % 2) == 1;
      v[6] = ($urandom_range(99) < 2);
      v[5] = ($urandom_range(99) < 20);
      v[4] = ($urandom_range(99) < 10);
      v[3] = ($urandom_range(99) < 5);
      v[2] = ($urandom_range(99) < 80);
      v[1] = ($urandom_range(99) < 30);
      v[0] = ($urandom_range(99) < (slow ? 5 : 60));
      step(v, 0, 11'd0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
